uart_tx: RTL
============

# uart_tx

UART transmitter that serialises bytes onto an 8N1 line (start 0, 8 data bits LSB first, stop 1). It is the transmit partner of the team's UART receive path. It divides `clk` internally to the bit rate and accepts bytes via a valid/ready handshake. A one-byte holding register lets the next byte be accepted mid-frame, so back-to-back frames go out with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 5208: clk cycles per bit (50 MHz / 9600 baud); legal ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled only on handshake.
- `tx_valid`  in  1  producer has a byte on `tx_data`.
- `tx_ready`  out  1  holding register empty; `tx_valid && tx_ready` at a rising edge = byte accepted.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  frame in progress (state ≠ IDLE).
- `tx_done`  out  1  one-cycle pulse on completion of each stop bit.

## Operation
- Storage: holding register `hold` plus `hold_full` flag; 8-bit shift register; bit-period counter 0..CLKS_PER_BIT-1; 3-bit data-bit index.
- `tx_ready` = !`hold_full`, driven directly from the register. `tx_valid` while not ready is ignored; `hold` is unchanged.
- States:
  - IDLE: `tx`=1. If `hold_full`: copy `hold` to shift reg, clear `hold_full`, clear counter → START.
  - START: `tx`=0 for one bit period → DATA, index=0.
  - DATA: `tx`=shift[0]. At end of each period shift right and increment index. After index 7's period → STOP.
  - STOP: `tx`=1 for one bit period. At its end assert `tx_done`. If `hold_full`, reload shift reg and clear `hold_full` → START (no idle cycle). Otherwise → IDLE.
- End of bit period = counter == CLKS_PER_BIT-1. The counter clears at every state transition.
- Accept and transfer never occur on the same edge, because `tx_ready`=0 whenever `hold_full`=1.
- Reset (any time, including mid-frame) at the edge where `rst_n`=0:
  - state=IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, `hold_full`=0.
  - Counter, index and shift reg clear. An in-flight frame is abandoned with no `tx_done`.
- `tx` is a registered output with no combinational path from inputs.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
- Handshake at edge N with state IDLE:
  - `tx_ready`=0 after edge N.
  - Edge N+1: START, `tx`=0, `tx_busy`=1, `tx_ready`=1.
- Every bit lasts exactly CLKS_PER_BIT cycles. A frame lasts 10·CLKS_PER_BIT cycles from edge N+1.
- `tx_done` is high for exactly the one cycle after edge N+1+10·CLKS_PER_BIT, the edge that leaves STOP.
- Back-to-back: if the next byte is accepted any time before the final stop-bit edge, the next start bit begins on that same edge.
- `tx_data` changes after a handshake have no effect on the byte being held or sent.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset check: hold `rst_n`=0 for 3 cycles with `tx_valid`=1 -> `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 throughout; nothing is accepted.
- Single byte: handshake 0xA5 at edge N ->
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, starting at edge N+1.
  - `tx_done` pulse after edge N+41; `tx_busy` drops at the same edge.
- Back-to-back: 0x00 accepted, then 0xFF accepted during the first frame's data bits ->
  - 80 contiguous cycles of frames with no idle-high gap between the first stop bit and the second start bit.
  - Two `tx_done` pulses exactly 40 cycles apart.
- Backpressure: with `hold_full`=1 (0x11 held), drive `tx_valid`=1 with 0x3C -> no acceptance; 0x11 transmits unchanged; 0x3C is accepted only once `tx_ready` returns to 1.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x5A ->
  - `tx`=1 and `tx_ready`=1 after that edge; no `tx_done`.
  - Following handshake of 0x81 yields a correct frame 0,1,0,0,0,0,0,0,1,1.
- Data stability: change `tx_data` 0x96→0x00 one cycle after the handshake -> 0x96 is transmitted.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte input, one-byte holding register,
// internal bit-period divider, registered serial output.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // Handshake: a byte is accepted at a rising clk edge where tx_valid && tx_ready;
  // tx_data is sampled only on that edge and tx_valid is ignored while tx_ready is low.

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    tx_d        = 1'b1;
    bit_end     = (cnt_q == LAST);

    // Accept only into an empty holding register; a transfer out of it
    // below therefore never collides with an accept on the same edge.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          done_d = 1'b1;
          // Chain straight into the next start bit when a byte is waiting.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != S_IDLE);

endmodule
